// File: rtl/alu_pkg.sv
// Shared opcode encodings and FSM state type for the ALU result unit.
// Both the combinational core and the registered top import this package.
package alu_pkg;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_SLTI = 3'b001;
  localparam logic [2:0] OP_OR   = 3'b010;
  localparam logic [2:0] OP_XOR  = 3'b011;
  localparam logic [2:0] OP_ADD  = 3'b100;
  localparam logic [2:0] OP_ADDI = 3'b101;
  localparam logic [2:0] OP_SLT  = 3'b110;
  localparam logic [2:0] OP_SRA  = 3'b111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/alu_comb_core.sv
// Single-cycle ALU datapath: the 8:1 result-select tree widened to WIDTH bits.
// SRA is produced by the iterator in the top level, so this core returns zero for it.
module alu_comb_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             bneg,
  output logic [WIDTH-1:0] result,
  output logic             ovf
);

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] sum;
  logic             add_ovf;
  logic             slt;

  // Subtraction is a + ~b + 1; the +1 enters as the carry-in.
  always_comb begin
    b_eff   = bneg ? ~b : b;
    sum     = a + b_eff + {{(WIDTH-1){1'b0}}, bneg};
    add_ovf = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    slt     = $signed(a) < $signed(b);
  end

  always_comb begin
    result = '0;
    ovf    = 1'b0;
    case (op)
      OP_AND:  result = a & b;
      OP_SLTI: result = {{(WIDTH-1){1'b0}}, slt};
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_ADD,
      OP_ADDI: begin
        result = sum;
        ovf    = add_ovf;
      end
      OP_SLT:  result = {{(WIDTH-1){1'b0}}, slt};
      OP_SRA:  result = '0;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu_result_unit.sv
// Registered ALU result stage with valid/ready handshakes and an iterative
// arithmetic shift right; sits between operand fetch and writeback.
module alu_result_unit
  import alu_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic             bneg,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             ovf,
  output state_t           dbg_state
);

  // Handshake: a transfer happens on a cycle where valid && ready are both high.
  // in_ready never looks at in_valid; out_valid/result stay stable until taken.
  state_t state, state_nxt;

  logic [WIDTH-1:0]   result_q;
  logic               zero_q;
  logic               ovf_q;
  logic [WIDTH-1:0]   shreg;
  logic [SHAMT_W-1:0] cnt;

  logic [WIDTH-1:0]   core_result;
  logic               core_ovf;
  logic [WIDTH-1:0]   shift_next;
  logic               accept;
  logic               load_res;
  logic               load_sra;
  logic               shift_step;
  logic               shift_done;

  alu_comb_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .a      (a),
    .b      (b),
    .op     (op),
    .bneg   (bneg),
    .result (core_result),
    .ovf    (core_ovf)
  );

  assign in_ready  = (state == IDLE) || ((state == HOLD) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == HOLD);
  assign result    = result_q;
  assign zero      = zero_q;
  assign ovf       = ovf_q;
  assign dbg_state = state;

  // A zero shift amount still spends one SHIFT cycle but leaves the value untouched.
  assign shift_next = (cnt == '0) ? shreg : {shreg[WIDTH-1], shreg[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    load_res   = 1'b0;
    load_sra   = 1'b0;
    shift_step = 1'b0;
    shift_done = 1'b0;
    case (state)
      IDLE, HOLD: begin
        if (accept) begin
          if (op == OP_SRA) begin
            load_sra  = 1'b1;
            state_nxt = SHIFT;
          end else begin
            load_res  = 1'b1;
            state_nxt = HOLD;
          end
        end else if ((state == HOLD) && out_ready) begin
          state_nxt = IDLE;
        end
      end
      SHIFT: begin
        // The last step (count 1) or the no-op step (count 0) writes the result.
        if (cnt <= SHAMT_W'(1)) begin
          shift_done = 1'b1;
          state_nxt  = HOLD;
        end else begin
          shift_step = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      zero_q   <= 1'b1;
      ovf_q    <= 1'b0;
    end else if (load_res) begin
      result_q <= core_result;
      zero_q   <= (core_result == '0);
      ovf_q    <= core_ovf;
    end else if (shift_done) begin
      result_q <= shift_next;
      zero_q   <= (shift_next == '0);
      ovf_q    <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (load_sra) begin
      shreg <= a;
      cnt   <= b[SHAMT_W-1:0];
    end else if (shift_step) begin
      shreg <= shift_next;
      cnt   <= cnt - SHAMT_W'(1);
    end
  end

endmodule

// File: tb/tb_alu_result_unit.sv
// Directed bench for alu_result_unit at WIDTH=16 with hand-computed expectations.
module tb_alu_result_unit;
  import alu_pkg::*;

  localparam int W = 16;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   op;
  logic         bneg;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         zero;
  logic         ovf;
  state_t       dbg_state;

  int checks = 0;
  int errors = 0;

  alu_result_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .bneg      (bneg),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .ovf       (ovf),
    .dbg_state (dbg_state)
  );

  // Clock and reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Driver: present one request for exactly one clock edge.
  task automatic issue(input logic [2:0] o, input logic bn, input logic [W-1:0] av,
                       input logic [W-1:0] bv);
    in_valid = 1'b1;
    op       = o;
    bneg     = bn;
    a        = av;
    b        = bv;
    tick();
    in_valid = 1'b0;
    a        = 16'hDEAD;
    b        = 16'hBEEF;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [W-1:0] r,
                         input logic z, input logic o);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(v));
    chk({tag, ".result"},    32'(result),    32'(r));
    chk({tag, ".zero"},      32'(zero),      32'(z));
    chk({tag, ".ovf"},       32'(ovf),       32'(o));
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    op        = OP_AND;
    bneg      = 1'b0;
    a         = '0;
    b         = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    chk_out("reset", 1'b0, 16'h0000, 1'b1, 1'b0);
    chk("reset.in_ready", 32'(in_ready), 32'd1);
    chk("reset.state", 32'(dbg_state), 32'(IDLE));

    out_ready = 1'b1;
    issue(OP_ADD, 1'b0, 16'h7FFF, 16'h0001);
    chk_out("add_ovf", 1'b1, 16'h8000, 1'b0, 1'b1);

    issue(OP_ADD, 1'b1, 16'h1234, 16'h1234);
    chk_out("sub_zero", 1'b1, 16'h0000, 1'b1, 1'b0);

    issue(OP_ADDI, 1'b1, 16'h8000, 16'h0001);
    chk_out("subi_ovf", 1'b1, 16'h7FFF, 1'b0, 1'b1);

    issue(OP_ADDI, 1'b0, 16'h0010, 16'hFFFF);
    chk_out("addi_neg", 1'b1, 16'h000F, 1'b0, 1'b0);

    issue(OP_SLT, 1'b0, 16'hFFFE, 16'h0003);
    chk_out("slt", 1'b1, 16'h0001, 1'b0, 1'b0);

    issue(OP_SLTI, 1'b0, 16'h0005, 16'hFFFF);
    chk_out("slti", 1'b1, 16'h0000, 1'b1, 1'b0);

    issue(OP_OR, 1'b1, 16'h00F0, 16'h0F00);
    chk_out("or", 1'b1, 16'h0FF0, 1'b0, 1'b0);

    tick();
    chk("drain.out_valid", 32'(out_valid), 32'd0);
    chk("drain.state", 32'(dbg_state), 32'(IDLE));

    issue(OP_SRA, 1'b0, 16'h8000, 16'h0004);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("sra4.in_ready[%0d]", i), 32'(in_ready), 32'd0);
      chk($sformatf("sra4.out_valid[%0d]", i), 32'(out_valid), 32'd0);
      tick();
    end
    chk_out("sra4", 1'b1, 16'hF800, 1'b0, 1'b0);

    issue(OP_SRA, 1'b0, 16'h8000, 16'h0000);
    chk("sra0.out_valid_c1", 32'(out_valid), 32'd0);
    chk("sra0.state_c1", 32'(dbg_state), 32'(SHIFT));
    tick();
    chk_out("sra0", 1'b1, 16'h8000, 1'b0, 1'b0);

    // Upper bits of b are ignored: 0x0013 shifts by 3.
    issue(OP_SRA, 1'b0, 16'h4000, 16'h0013);
    repeat (2) tick();
    chk("sra3.out_valid_c3", 32'(out_valid), 32'd0);
    tick();
    chk_out("sra3", 1'b1, 16'h0800, 1'b0, 1'b0);

    issue(OP_XOR, 1'b0, 16'h00FF, 16'h0F0F);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    op        = OP_AND;
    a         = 16'hFFFF;
    b         = 16'h0000;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("bp.in_ready[%0d]", i), 32'(in_ready), 32'd0);
      chk_out($sformatf("bp[%0d]", i), 1'b1, 16'h0FF0, 1'b0, 1'b0);
      tick();
    end

    out_ready = 1'b1;
    a         = 16'hF0F0;
    b         = 16'h3C3C;
    #1;
    chk("b2b.in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk_out("b2b_and", 1'b1, 16'h3030, 1'b0, 1'b0);

    tick();
    chk("idle2.state", 32'(dbg_state), 32'(IDLE));

    issue(OP_SRA, 1'b0, 16'h8000, 16'h0008);
    tick();
    chk("abort.pre_state", 32'(dbg_state), 32'(SHIFT));
    #2 rst_n = 1'b0;
    #1;
    chk_out("abort", 1'b0, 16'h0000, 1'b1, 1'b0);
    chk("abort.state", 32'(dbg_state), 32'(IDLE));
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("abort.no_stale[%0d]", i), 32'(out_valid), 32'd0);
    end

    issue(OP_ADD, 1'b0, 16'h0003, 16'h0004);
    chk_out("post_abort_add", 1'b1, 16'h0007, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
